// File: rtl/reg_writeback_pkg.sv
// Shared core definitions for the register write-back stage.
//   - CPSR flag bit positions and reset value
//   - PC read offset applied when r15 is read
//   - R15 index, write-source selector and write request struct
package reg_writeback_pkg;

    // CPSR condition flag positions
    localparam int unsigned CpsrNBit = 31;
    localparam int unsigned CpsrZBit = 30;
    localparam int unsigned CpsrCBit = 29;
    localparam int unsigned CpsrVBit = 28;

    // Supervisor mode, IRQ and FIQ masked
    localparam logic [31:0] CpsrResetVal = 32'h000000D3;

    // r15 reads see the instruction address plus the pipeline offset
    localparam logic [31:0] PcReadOffset = 32'd8;

    localparam logic [3:0] R15Idx = 4'd15;

    typedef enum logic [1:0] {
        SrcNone,
        SrcEx,
        SrcQueue,
        SrcLoad
    } wr_src_e;

    typedef struct packed {
        logic        en;
        logic [3:0]  num;
        logic [31:0] data;
    } wr_req_t;

    function automatic logic is_pc(input logic [3:0] num);
        return num == R15Idx;
    endfunction

endpackage

// File: rtl/ld_queue.sv
// Load-result FIFO for the write-back stage.
// Entry 0 is always the head; a pop shifts the remaining entries down.
// Ports:
//   clk, Nrst             clock, asynchronous active-low reset (clears count)
//   push, push_num/data   enqueue one load result
//   pop                   dequeue the head
//   count                 number of valid entries
//   head_num/head_data    oldest entry
//   ent_num, ent_valid    destination number and validity of every slot
module ld_queue #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              Nrst,
    input  logic              push,
    input  logic [3:0]        push_num,
    input  logic [31:0]       push_data,
    input  logic              pop,
    output logic [CntW-1:0]   count,
    output logic [3:0]        head_num,
    output logic [31:0]       head_data,
    output logic [DEPTH*4-1:0] ent_num,
    output logic [DEPTH-1:0]  ent_valid
);

    logic [3:0]      num_q  [DEPTH];
    logic [3:0]      num_d  [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        int wr_pos;
        for (int k = 0; k < DEPTH; k++) begin
            num_d[k]  = num_q[k];
            data_d[k] = data_q[k];
        end
        if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                num_d[k]  = num_q[k + 1];
                data_d[k] = data_q[k + 1];
            end
        end
        // New entry lands just past the last survivor of this cycle's pop
        wr_pos = int'(count_q) - (pop ? 1 : 0);
        if (push) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k == wr_pos) begin
                    num_d[k]  = push_num;
                    data_d[k] = push_data;
                end
            end
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    // Payload needs no reset: validity comes from count alone
    always_ff @(posedge clk) begin
        num_q  <= num_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_num[k*4 +: 4] = num_q[k];
            ent_valid[k]      = k < int'(count_q);
        end
    end

    assign count     = count_q;
    assign head_num  = num_q[0];
    assign head_data = data_q[0];

endmodule

// File: rtl/reg_writeback.sv
// Register file and write-back stage.
// One write per cycle into a 16x32 array, chosen from the Execute result,
// the load queue head, or a directly written load. Writes to r15 become a
// one-cycle redirect instead of a register update.
// Ports:
//   clk, Nrst                      clock, asynchronous active-low reset
//   flush, ex_bubble               qualify the Execute result
//   ex_write_reg/num/data, ex_cpsr Execute result and CPSR
//   ld_valid/num/data, ld_ready    load-result handshake from memory
//   rd_num0..2, rd_data0..2        combinational read ports
//   rd_pend                        per-port pending-load hazard
//   pc                             PC of the reading instruction
//   cpsr                           architectural CPSR
//   jmp, jmp_pc                    redirect pulse and target
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned LDQ_DEPTH      = 2,
    parameter logic [31:0] PC_READ_OFFSET = PcReadOffset
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        flush,
    input  logic        ex_bubble,
    input  logic        ex_write_reg,
    input  logic [3:0]  ex_write_num,
    input  logic [31:0] ex_write_data,
    input  logic [31:0] ex_cpsr,
    input  logic        ld_valid,
    input  logic [3:0]  ld_num,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [3:0]  rd_num0,
    input  logic [3:0]  rd_num1,
    input  logic [3:0]  rd_num2,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic [2:0]  rd_pend,
    input  logic [31:0] pc,
    output logic [31:0] cpsr,
    output logic        jmp,
    output logic [31:0] jmp_pc
);

    localparam int unsigned CntW = $clog2(LDQ_DEPTH + 1);

    logic ex_valid, ex_wr, ld_accept, q_empty, q_push, q_pop;
    wr_src_e wr_src;
    wr_req_t wr;

    logic [CntW-1:0]        q_count;
    logic [3:0]             q_head_num;
    logic [31:0]            q_head_data;
    logic [LDQ_DEPTH*4-1:0] q_ent_num;
    logic [LDQ_DEPTH-1:0]   q_ent_valid;

    logic [31:0] regs_q [16];
    logic [31:0] cpsr_q;
    logic        jmp_q;
    logic [31:0] jmp_pc_q;

    logic [3:0]  rd_num_a  [3];
    logic [31:0] rd_data_a [3];

    assign ex_valid  = !ex_bubble && !flush;
    assign ex_wr     = ex_valid && ex_write_reg;
    assign ld_ready  = q_count != CntW'(LDQ_DEPTH);
    assign ld_accept = ld_valid && ld_ready;
    assign q_empty   = q_count == '0;

    // Execute wins; queued loads drain before a fresh load may bypass the queue
    always_comb begin
        if (ex_wr) begin
            wr_src = SrcEx;
        end else if (!q_empty) begin
            wr_src = SrcQueue;
        end else if (ld_accept) begin
            wr_src = SrcLoad;
        end else begin
            wr_src = SrcNone;
        end
    end

    always_comb begin
        wr = '0;
        unique case (wr_src)
            SrcEx:    wr = '{en: 1'b1, num: ex_write_num, data: ex_write_data};
            SrcQueue: wr = '{en: 1'b1, num: q_head_num, data: q_head_data};
            SrcLoad:  wr = '{en: 1'b1, num: ld_num, data: ld_data};
            SrcNone:  wr = '0;
        endcase
    end

    assign q_pop  = wr_src == SrcQueue;
    assign q_push = ld_accept && (wr_src != SrcLoad);

    ld_queue #(
        .DEPTH(LDQ_DEPTH)
    ) u_ld_queue (
        .clk      (clk),
        .Nrst     (Nrst),
        .push     (q_push),
        .push_num (ld_num),
        .push_data(ld_data),
        .pop      (q_pop),
        .count    (q_count),
        .head_num (q_head_num),
        .head_data(q_head_data),
        .ent_num  (q_ent_num),
        .ent_valid(q_ent_valid)
    );

    // Array is deliberately not reset; reset only blocks writes
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
        end else if (wr.en && !is_pc(wr.num)) begin
            regs_q[wr.num] <= wr.data;
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            cpsr_q   <= CpsrResetVal;
            jmp_q    <= 1'b0;
            jmp_pc_q <= '0;
        end else begin
            if (ex_valid) begin
                cpsr_q <= ex_cpsr;
            end
            jmp_q <= wr.en && is_pc(wr.num);
            if (wr.en && is_pc(wr.num)) begin
                jmp_pc_q <= wr.data;
            end
        end
    end

    assign cpsr   = cpsr_q;
    assign jmp    = jmp_q;
    assign jmp_pc = jmp_pc_q;

    assign rd_num_a[0] = rd_num0;
    assign rd_num_a[1] = rd_num1;
    assign rd_num_a[2] = rd_num2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (is_pc(rd_num_a[i])) begin
                rd_data_a[i] = pc + PC_READ_OFFSET;
            end else if (wr.en && wr.num == rd_num_a[i]) begin
                rd_data_a[i] = wr.data;
            end else begin
                rd_data_a[i] = regs_q[rd_num_a[i]];
            end
        end
    end

    assign rd_data0 = rd_data_a[0];
    assign rd_data1 = rd_data_a[1];
    assign rd_data2 = rd_data_a[2];

    // The head being popped this cycle is already visible through the bypass
    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < 3; i++) begin
            if (!is_pc(rd_num_a[i])) begin
                for (int k = 0; k < LDQ_DEPTH; k++) begin
                    if (q_ent_valid[k] && !(k == 0 && q_pop) &&
                        q_ent_num[k*4 +: 4] == rd_num_a[i]) begin
                        rd_pend[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus a
// scoreboard of expected register contents checked after the traffic.
module tb_reg_writeback;

    logic        clk, Nrst;
    logic        flush, ex_bubble, ex_write_reg;
    logic [3:0]  ex_write_num;
    logic [31:0] ex_write_data, ex_cpsr;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_num;
    logic [31:0] ld_data;
    logic [3:0]  rd_num0, rd_num1, rd_num2;
    logic [31:0] rd_data0, rd_data1, rd_data2;
    logic [2:0]  rd_pend;
    logic [31:0] pc, cpsr, jmp_pc;
    logic        jmp;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [16];
    int unsigned sb_q [$];
    logic [31:0] exp_cpsr;

    reg_writeback #(
        .LDQ_DEPTH(2),
        .PC_READ_OFFSET(32'd8)
    ) dut (
        .clk          (clk),
        .Nrst         (Nrst),
        .flush        (flush),
        .ex_bubble    (ex_bubble),
        .ex_write_reg (ex_write_reg),
        .ex_write_num (ex_write_num),
        .ex_write_data(ex_write_data),
        .ex_cpsr      (ex_cpsr),
        .ld_valid     (ld_valid),
        .ld_num       (ld_num),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .rd_num0      (rd_num0),
        .rd_num1      (rd_num1),
        .rd_num2      (rd_num2),
        .rd_data0     (rd_data0),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .rd_pend      (rd_pend),
        .pc           (pc),
        .cpsr         (cpsr),
        .jmp          (jmp),
        .jmp_pc       (jmp_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] num, input logic [31:0] data);
        model[num] = data;
        sb_q.push_back(int'(num));
    endtask

    task automatic idle();
        ex_bubble    = 1'b1;
        flush        = 1'b0;
        ex_write_reg = 1'b0;
        ld_valid     = 1'b0;
    endtask

    task automatic ex_write(input logic [3:0] num, input logic [31:0] data);
        ex_bubble     = 1'b0;
        flush         = 1'b0;
        ex_write_reg  = 1'b1;
        ex_write_num  = num;
        ex_write_data = data;
        ex_cpsr       = exp_cpsr;
    endtask

    task automatic load(input logic [3:0] num, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_num   = num;
        ld_data  = data;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit accepted;
        Nrst = 1'b0;
        idle();
        ex_write_num = '0; ex_write_data = '0; ex_cpsr = '0;
        ld_num = '0; ld_data = '0;
        rd_num0 = 4'd0; rd_num1 = 4'd0; rd_num2 = 4'd0;
        pc = 32'h0;
        exp_cpsr = 32'h000000D3;

        #12;
        check("rst_cpsr", cpsr, 32'h000000D3);
        check("rst_jmp", {31'b0, jmp}, 32'h0);
        check("rst_jmp_pc", jmp_pc, 32'h0);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
        check("rst_rd_pend", {29'b0, rd_pend}, 32'h0);
        next();
        Nrst = 1'b1;

        // Bypass then array read, with a CPSR update
        exp_cpsr = 32'h600000D3;
        ex_write(4'd3, 32'h12345678);
        rd_num0 = 4'd3;
        @(negedge clk);
        check("bypass_r3", rd_data0, 32'h12345678);
        expect_write(4'd3, 32'h12345678);
        next();
        idle();
        @(negedge clk);
        check("array_r3", rd_data0, 32'h12345678);
        check("cpsr_upd", cpsr, exp_cpsr);
        next();

        // Execute write and load in the same cycle: load goes to the queue
        ex_write(4'd4, 32'h44);
        load(4'd5, 32'hA5);
        rd_num1 = 4'd5;
        expect_write(4'd4, 32'h44);
        expect_write(4'd5, 32'hA5);
        next();
        ex_write(4'd6, 32'h66);
        ld_valid = 1'b0;
        expect_write(4'd6, 32'h66);
        @(negedge clk);
        check("pend_r5", {29'b0, rd_pend}, 32'h2);
        next();
        idle();
        @(negedge clk);
        check("pend_r5_pop", {29'b0, rd_pend}, 32'h0);
        check("bypass_pop_r5", rd_data1, 32'hA5);
        next();

        // Queue fills while Execute keeps writing; third load is held
        ex_write(4'd7, 32'h77);
        load(4'd10, 32'hA0);
        expect_write(4'd7, 32'h77);
        expect_write(4'd10, 32'hA0);
        @(negedge clk);
        check("fill_ready_a", {31'b0, ld_ready}, 32'h1);
        next();
        ex_write(4'd8, 32'h88);
        load(4'd11, 32'hB1);
        expect_write(4'd8, 32'h88);
        expect_write(4'd11, 32'hB1);
        @(negedge clk);
        check("fill_ready_b", {31'b0, ld_ready}, 32'h1);
        next();
        ex_write(4'd9, 32'h99);
        load(4'd10, 32'hC2);
        rd_num2 = 4'd10;
        expect_write(4'd9, 32'h99);
        @(negedge clk);
        check("fill_ready_c", {31'b0, ld_ready}, 32'h0);
        check("pend_r10", {29'b0, rd_pend}, 32'h4);
        next();
        idle();
        ld_valid = 1'b1;
        @(negedge clk);
        check("held_ready", {31'b0, ld_ready}, 32'h0);
        check("order_first_r10", rd_data2, 32'hA0);
        accepted = 1'b0;
        for (int n = 0; n < 6 && !accepted; n++) begin
            @(negedge clk);
            accepted = ld_ready;
            next();
        end
        check("held_accepted", {31'b0, accepted}, 32'h1);
        ld_valid = 1'b0;
        expect_write(4'd10, 32'hC2);
        @(negedge clk);
        check("order_last_r10", rd_data2, 32'hC2);
        next();
        next();
        check("queue_drained", {31'b0, ld_ready}, 32'h1);

        // r15 write becomes a one-cycle redirect
        ex_write(4'd15, 32'h00008000);
        @(negedge clk);
        check("jmp_before", {31'b0, jmp}, 32'h0);
        next();
        idle();
        @(negedge clk);
        check("jmp_pulse", {31'b0, jmp}, 32'h1);
        check("jmp_pc", jmp_pc, 32'h00008000);
        next();
        @(negedge clk);
        check("jmp_after", {31'b0, jmp}, 32'h0);
        rd_num0 = 4'd15;
        pc = 32'h100;
        #1;
        check("pc_read", rd_data0, 32'h108);
        pc = 32'hFFFFFFFC;
        #1;
        check("pc_wrap", rd_data0, 32'h4);
        next();

        // Flush suppresses the write and CPSR, but the queue still drains
        ex_write(4'd1, 32'h11);
        load(4'd2, 32'h22);
        expect_write(4'd1, 32'h11);
        expect_write(4'd2, 32'h22);
        next();
        ld_valid      = 1'b0;
        flush         = 1'b1;
        ex_bubble     = 1'b0;
        ex_write_reg  = 1'b1;
        ex_write_num  = 4'd1;
        ex_write_data = 32'hDEAD;
        ex_cpsr       = 32'hF00000D3;
        rd_num0       = 4'd2;
        @(negedge clk);
        check("flush_drain_r2", rd_data0, 32'h22);
        check("flush_pend", {29'b0, rd_pend}, 32'h0);
        next();
        idle();
        rd_num0 = 4'd1;
        @(negedge clk);
        check("flush_cpsr", cpsr, exp_cpsr);
        check("flush_r1", rd_data0, 32'h11);
        next();

        // CPSR updates on any valid cycle, even without a register write
        ex_bubble     = 1'b0;
        ex_write_reg  = 1'b0;
        ex_write_num  = 4'd1;
        ex_write_data = 32'hBEEF;
        ex_cpsr       = 32'h200000D3;
        exp_cpsr      = 32'h200000D3;
        next();
        idle();
        @(negedge clk);
        check("cpsr_only", cpsr, exp_cpsr);
        check("cpsr_only_r1", rd_data0, 32'h11);
        next();

        // Reset with two loads queued discards them
        ex_write(4'd0, 32'h1000);
        expect_write(4'd0, 32'h1000);
        next();
        ex_write(4'd14, 32'h1400);
        expect_write(4'd14, 32'h1400);
        next();
        ex_write(4'd13, 32'h1313);
        load(4'd0, 32'hBAD0);
        next();
        ex_write(4'd13, 32'h1314);
        load(4'd14, 32'hBAD1);
        expect_write(4'd13, 32'h1314);
        next();
        idle();
        rd_num0 = 4'd0;
        rd_num1 = 4'd14;
        rd_num2 = 4'd3;
        @(negedge clk);
        check("prerst_ready", {31'b0, ld_ready}, 32'h0);
        check("prerst_pend", {29'b0, rd_pend}, 32'h2);
        #1;
        Nrst = 1'b0;
        #1;
        check("midrst_cpsr", cpsr, 32'h000000D3);
        check("midrst_ready", {31'b0, ld_ready}, 32'h1);
        check("midrst_pend", {29'b0, rd_pend}, 32'h0);
        exp_cpsr = 32'h000000D3;
        next();
        next();
        Nrst = 1'b1;
        next();
        next();

        // Scoreboard drain: final register contents
        while (sb_q.size() > 0) begin
            int unsigned n;
            n = sb_q.pop_front();
            rd_num0 = 4'(n);
            #1;
            check($sformatf("sb_r%0d", n), rd_data0, model[n]);
        end
        check("final_cpsr", cpsr, exp_cpsr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
